// File: rtl/aging_qos_scheduler.sv
// aging_qos_scheduler
//
// Owns one shared resource port and hands it to one of N requesters at a time.
// The winner is the requester with the highest effective priority, which is its
// QoS plus its age. Ties go to the first requester found scanning upward from a
// round-robin pointer. A grant is held for a whole burst. The burst ends when
// the owner pulses done, when the owner drops its request, or when the beat cap
// is reached. One dead cycle always separates consecutive owners.
//
// Ports:
//   clk         : clock; all state changes on the rising edge
//   rst         : asynchronous active-high reset
//   req[N]      : level request per requester
//   qos[N*QW]   : QoS of requester i at bits [i*QW +: QW]; the larger value wins
//   beat        : the shared resource finished one beat for the current owner
//   done        : single-cycle pulse from the owner ending its burst
//   grant[N]    : one-hot registered grant
//   grant_valid : high while grant is nonzero
//   grant_idx   : index of the granted requester, 0 when there is no grant
//   busy        : high while a burst is in progress
module aging_qos_scheduler #(
    parameter int N         = 8,
    parameter int QW        = 4,
    parameter int AGE_W     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*QW-1:0]      qos,
    input  logic                 beat,
    input  logic                 done,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    // One extra bit so that qos + age can never wrap.
    localparam int EW = ((QW > AGE_W) ? QW : AGE_W) + 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    logic [IW-1:0]     rr_ptr;
    logic [CW-1:0]     beat_cnt;
    logic [AGE_W-1:0]  age [N];

    logic [IW-1:0]     winner;
    logic [EW-1:0]     best_eff;
    logic              found;
    logic              burst_end;

    // Ages stop at the top value instead of wrapping back to zero.
    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a == {AGE_W{1'b1}}) ? a : a + 1'b1;
    endfunction

    function automatic logic [EW-1:0] eff_prio(input logic [QW-1:0] q,
                                               input logic [AGE_W-1:0] a);
        return EW'(q) + EW'(a);
    endfunction

    // Arbitration: scan starts at rr_ptr. A candidate replaces the current
    // best only when its priority is strictly greater, so on a tie the first
    // index met after rr_ptr keeps the grant.
    always_comb begin
        found    = 1'b0;
        best_eff = '0;
        winner   = '0;
        for (int k = 0; k < N; k++) begin
            logic [IW-1:0] cand;
            logic [EW-1:0] eff;
            cand = rr_ptr + IW'(k);
            eff  = eff_prio(qos[int'(cand)*QW +: QW], age[cand]);
            if (req[cand] && (!found || (eff > best_eff))) begin
                found    = 1'b1;
                best_eff = eff;
                winner   = cand;
            end
        end
    end

    // Any one of the three end conditions closes the burst. A final beat
    // that coincides with done or a request drop still counts as delivered.
    assign burst_end = done | ~req[grant_idx] | (beat & (beat_cnt == LAST_BEAT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            for (int i = 0; i < N; i++) begin
                age[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // Non-requesters forget their age. The winner restarts
                    // from zero and each losing requester grows one step older.
                    for (int i = 0; i < N; i++) begin
                        if (!req[i] || (IW'(i) == winner)) begin
                            age[i] <= '0;
                        end else begin
                            age[i] <= age_sat_inc(age[i]);
                        end
                    end
                    if (|req) begin
                        state     <= GRANT;
                        grant     <= N'(1) << winner;
                        grant_idx <= winner;
                        rr_ptr    <= winner + 1'b1;
                        beat_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (burst_end) begin
                        state     <= IDLE;
                        grant     <= '0;
                        grant_idx <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    grant_idx <= '0;
                end
            endcase
        end
    end

    assign grant_valid = |grant;
    assign busy        = (state == GRANT);

endmodule

// File: tb/tb_aging_qos_scheduler.sv
module tb_aging_qos_scheduler;

    localparam int N         = 8;
    localparam int QW        = 4;
    localparam int AGE_W     = 4;
    localparam int MAX_BURST = 16;
    localparam int AGE_MAX   = (1 << AGE_W) - 1;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N*QW-1:0]      qos;
    logic                 beat;
    logic                 done;
    logic [N-1:0]         grant;
    logic                 grant_valid;
    logic [$clog2(N)-1:0] grant_idx;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, ages as integers, and the pointer
    // that decides ties.
    int m_age [N];
    bit m_busy;
    int m_owner;
    int m_rr;
    int m_beats;

    aging_qos_scheduler #(
        .N(N), .QW(QW), .AGE_W(AGE_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .qos(qos),
        .beat(beat),
        .done(done),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_age[i] = 0;
        m_busy  = 1'b0;
        m_owner = 0;
        m_rr    = 0;
        m_beats = 0;
    endtask

    // Applies one clock of the scheduling rules to the model, using the inputs
    // currently driven.
    task automatic model_update();
        int best, best_eff, best_dist, e, d;
        if (!m_busy) begin
            if (req != 0) begin
                best = -1; best_eff = 0; best_dist = 0;
                for (int i = 0; i < N; i++) begin
                    if (req[i]) begin
                        e = int'(qos[i*QW +: QW]) + m_age[i];
                        d = (i - m_rr + N) % N;
                        if (best < 0 || e > best_eff || (e == best_eff && d < best_dist)) begin
                            best = i; best_eff = e; best_dist = d;
                        end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (!req[i] || i == best) m_age[i] = 0;
                    else if (m_age[i] < AGE_MAX) m_age[i] = m_age[i] + 1;
                end
                m_busy  = 1'b1;
                m_owner = best;
                m_rr    = (best + 1) % N;
                m_beats = 0;
            end else begin
                for (int i = 0; i < N; i++) m_age[i] = 0;
            end
        end else begin
            if (done || !req[m_owner] || (beat && m_beats + 1 == MAX_BURST)) begin
                m_busy = 1'b0;
            end else if (beat) begin
                m_beats++;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic [N-1:0] exp_grant;
        exp_grant = m_busy ? (N'(1) << m_owner) : '0;
        check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
        check({tag, ".idx"}, 32'(grant_idx), m_busy ? 32'(m_owner) : 32'd0);
        check({tag, ".valid"}, 32'(grant_valid), 32'(m_busy));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    endtask

    // One clock: model steps on the driven inputs, DUT is sampled 1 ns after the edge.
    task automatic cycle(input string tag);
        model_update();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic expect_idx(input string tag, input int idx);
        check({tag, ".grant"}, 32'(grant), 32'(1) << idx);
        check({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    endtask

    task automatic expect_none(input string tag);
        check({tag, ".grant"}, 32'(grant), 32'd0);
        check({tag, ".valid"}, 32'(grant_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        qos  = '0;
        beat = 1'b0;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("reset.grant", 32'(grant), 32'd0);
        check("reset.valid", 32'(grant_valid), 32'd0);
        check("reset.idx", 32'(grant_idx), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
    endtask

    task automatic pulse_done(input string tag);
        done = 1'b1;
        cycle(tag);
        done = 1'b0;
        expect_none(tag);
    endtask

    initial begin
        model_reset();

        // Idle with no requests.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle("idle");
            check("idle.busy0", 32'(busy), 32'd0);
        end

        // Single requester, done, then regrant.
        do_reset();
        req[3] = 1'b1; qos[3*QW +: QW] = 4'd5;
        cycle("single.arb");
        expect_idx("single.first", 3);
        pulse_done("single.done");
        cycle("single.regrant");
        expect_idx("single.regrant", 3);

        // Higher QoS wins twice in a row while the loser ages.
        do_reset();
        req[1] = 1'b1; qos[1*QW +: QW] = 4'd2;
        req[6] = 1'b1; qos[6*QW +: QW] = 4'd9;
        cycle("qos.arb1");
        expect_idx("qos.first", 6);
        pulse_done("qos.done");
        cycle("qos.arb2");
        expect_idx("qos.second", 6);

        // Equal QoS alternates through the round-robin pointer.
        do_reset();
        req[2] = 1'b1; qos[2*QW +: QW] = 4'd12;
        req[5] = 1'b1; qos[5*QW +: QW] = 4'd12;
        cycle("rr.arb1");
        expect_idx("rr.first", 2);
        pulse_done("rr.done1");
        cycle("rr.arb2");
        expect_idx("rr.second", 5);
        pulse_done("rr.done2");
        cycle("rr.arb3");
        expect_idx("rr.third", 2);

        // Aging lifts the low-QoS requester on the 8th arbitration.
        do_reset();
        req[0] = 1'b1; qos[0*QW +: QW] = 4'd3;
        req[7] = 1'b1; qos[7*QW +: QW] = 4'd10;
        for (int a = 1; a <= 8; a++) begin
            cycle("age.arb");
            expect_idx($sformatf("age.arb%0d", a), (a < 8) ? 7 : 0);
            pulse_done("age.done");
        end
        cycle("age.arb9");
        expect_idx("age.arb9", 7);

        // Beat cap: 16 beats, one dead cycle, regrant, then async reset mid-burst.
        do_reset();
        req[4] = 1'b1; qos[4*QW +: QW] = 4'd1;
        beat = 1'b1;
        cycle("cap.arb");
        expect_idx("cap.beat1", 4);
        for (int b = 2; b <= MAX_BURST; b++) begin
            cycle("cap.hold");
            expect_idx($sformatf("cap.beat%0d", b), 4);
        end
        cycle("cap.dead");
        expect_none("cap.dead");
        cycle("cap.regrant");
        expect_idx("cap.regrant", 4);
        cycle("cap.mid1");
        cycle("cap.mid2");
        #2;
        rst = 1'b1;
        #1;
        check("async.grant", 32'(grant), 32'd0);
        check("async.busy", 32'(busy), 32'd0);
        check("async.valid", 32'(grant_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat = 1'b0;
        model_reset();
        req = '0;
        cycle("async.after");

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) begin
                req = N'($urandom) & N'($urandom);
                qos = (N*QW)'($urandom);
            end
            if ($urandom_range(63) == 0) req = '0;
            beat = 1'($urandom);
            done = ($urandom_range(11) == 0);
            cycle("rand");
            check("rand.onehot", 32'($countones(grant) <= 1), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
